// File: rtl/mem_stage_dmem_responder_if.sv
// MEM-stage data-memory request/response bundle.
// The master is the EX_MEM side; the slave is the responder.
interface mem_stage_dmem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  writedatasel;
  logic [2:0]  readdatasel;
  logic        stall;
  logic [31:0] readdata;
  logic        misalign_err;

  modport master (
    output memread, memwrite, addr, wdata,
    output writedatasel, readdatasel,
    input  stall, readdata, misalign_err
  );

  modport slave (
    input  memread, memwrite, addr, wdata,
    input  writedatasel, readdatasel,
    output stall, readdata, misalign_err
  );
endinterface

// File: rtl/mem_stage_dmem_responder.sv
// Data-memory responder for the MEM stage.
// Fixed-latency byte-lane array with load extension and alignment checks.
module mem_stage_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic clk,
  input logic reset,
  mem_stage_dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] readdata_q, readdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req, bad, fire;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   word, load_val, wlanes;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;
  logic          unused_addr;

  assign req         = bus.memread | bus.memwrite;
  assign idx         = bus.addr[AW+1:2];
  assign off         = bus.addr[1:0];
  assign unused_addr = ^bus.addr[31:AW+2];

  always_comb begin
    bad = bus.memread & bus.memwrite;
    if (bus.memwrite) begin
      unique case (bus.writedatasel)
        2'b00:   bad = bad;
        2'b01:   bad = bad | off[0];
        2'b10:   bad = bad | (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    if (bus.memread) begin
      unique case (bus.readdatasel)
        3'b000, 3'b100: bad = bad;
        3'b001, 3'b101: bad = bad | off[0];
        3'b010:         bad = bad | (off != 2'b00);
        default:        bad = 1'b1;
      endcase
    end
  end

  assign word   = mem[idx];
  assign byte_v = word[{off, 3'b000} +: 8];
  assign half_v = word[{off[1], 4'b0000} +: 16];

  always_comb begin
    unique case (bus.readdatasel)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    unique case (bus.writedatasel)
      2'b00: begin
        be     = 4'b0001 << off;
        wlanes = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{bus.wdata[15:0]}};
      end
      2'b10: begin
        be     = 4'b1111;
        wlanes = bus.wdata;
      end
      default: begin
        be     = 4'b0000;
        wlanes = 32'd0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;
    err_d      = 1'b0;
    fire       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && bad) begin
          err_d      = 1'b1;
          readdata_d = 32'd0;
          state_d    = DONE;
        end else if (req) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = DONE;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = DONE;
            fire    = ~bad;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fire && bus.memread) readdata_d = load_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire && bus.memwrite && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // A rejected request is answered without holding the pipeline.
  assign bus.stall = req & ~bad & (state_q != DONE) & ~reset;
  assign bus.readdata     = readdata_q;
  assign bus.misalign_err = err_q;
endmodule
